ofd4_arb: RTL and testbench

Round-robin arbiter and burst sequencer that shares one 4-bit output-register bank (an `ofd4s` instance at the pad level) between `NREQ` nibble-stream requesters. It grants the bank to one requester at a time for a whole burst, which is closed by a last flag or by a beat limit. It inserts a programmable turnaround gap between owners and drives `D[3:0]` into the `ofd4s` D0..D3 inputs. The block sits in the core clock domain, directly ahead of the pad registers. It does not instantiate `ofd4s`, so IOB placement stays at the top level.

---
 rtl/ofd4_pkg.sv | 30 +++
 rtl/ofd4_rr_pick.sv | 48 ++++
 rtl/ofd4_arb.sv | 154 +++++++++++++++
 tb/tb_ofd4_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofd4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ofd4_pkg
// Brief    : Shared types and helpers for the ofd4 pad-bank arbiter.
// Revision : 1.0
// ============================================================================
package ofd4_pkg;

    localparam int OFD4_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ofd4_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : ofd4_rr_pick
// Brief    : One-hot circular priority picker starting at PTR.
// Revision : 1.0
// ============================================================================
module ofd4_rr_pick
    import ofd4_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] REQ,
    input  logic [PW-1:0]   PTR,
    output logic [NREQ-1:0] SEL
);

    logic [NREQ-1:0] w_hi_req;
    logic            w_found_hi;
    logic            w_found_lo;

    // Requests at or above PTR win; otherwise wrap to the lowest request.
    always_comb begin
        w_hi_req   = '0;
        SEL        = '0;
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_hi_req[i] = REQ[i] && (i >= int'(PTR));
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_hi_req[i] && !w_found_hi) begin
                SEL[i]     = 1'b1;
                w_found_hi = 1'b1;
            end
        end
        if (!w_found_hi) begin
            for (int i = 0; i < NREQ; i++) begin
                if (REQ[i] && !w_found_lo) begin
                    SEL[i]     = 1'b1;
                    w_found_lo = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ofd4_arb.sv
`default_nettype none
// ============================================================================
// Module   : ofd4_arb
// Brief    : Round-robin burst arbiter feeding a shared 4-bit pad register.
// Revision : 1.0
// ============================================================================
module ofd4_arb
    import ofd4_pkg::*;
#(
    parameter int                NREQ = 4,
    parameter int                GAP  = 2,
    parameter int                MAXB = 16,
    parameter logic [OFD4_W-1:0] IDLE = 4'h0
) (
    input  logic                     CK,
    input  logic                     RN,
    input  logic [NREQ-1:0]          VLD,
    input  logic [NREQ-1:0]          LST,
    input  logic [OFD4_W*NREQ-1:0]   DAT,
    output logic [NREQ-1:0]          RDY,
    output logic [OFD4_W-1:0]        D,
    output logic                     ACT,
    output logic [NREQ-1:0]          GNT,
    output logic                     ABRT
);

    localparam int             PW     = clog2(NREQ);
    localparam int             BCW    = clog2(MAXB + 1);
    localparam logic [3:0]     GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [BCW-1:0] BC_MAX = BCW'(MAXB);

    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_q,   gnt_d;
    logic [PW-1:0]       ptr_q,   ptr_d;
    logic [BCW-1:0]      bc_q,    bc_d;
    logic [3:0]          gap_q,   gap_d;
    logic [OFD4_W-1:0]   d_q,     d_d;
    logic                act_q,   act_d;
    logic                abrt_q,  abrt_d;

    logic [NREQ-1:0]     w_sel;
    logic [NREQ-1:0]     w_rdy;
    logic                w_acc;
    logic                w_lst;
    logic [OFD4_W-1:0]   w_dat;
    logic [BCW-1:0]      w_bc_inc;

    ofd4_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .REQ (VLD),
        .PTR (ptr_q),
        .SEL (w_sel)
    );

    assign w_rdy    = (state_q == ST_BURST) ? gnt_q : '0;
    assign w_acc    = |(VLD & w_rdy);
    assign w_lst    = |(LST & gnt_q);
    assign w_bc_inc = bc_q + BCW'(1);

    // GNT is one-hot, so OR-ing the masked nibbles selects the owner's data.
    always_comb begin
        w_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                w_dat = w_dat | DAT[OFD4_W*i +: OFD4_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        bc_d    = bc_q;
        gap_d   = gap_q;
        d_d     = IDLE;
        act_d   = 1'b0;
        abrt_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|VLD) begin
                    gnt_d   = w_sel;
                    bc_d    = '0;
                    state_d = ST_BURST;
                    for (int i = 0; i < NREQ; i++) begin
                        if (w_sel[i]) begin
                            ptr_d = (i == NREQ - 1) ? '0 : PW'(i + 1);
                        end
                    end
                end
            end
            ST_BURST: begin
                if (w_acc) begin
                    d_d   = w_dat;
                    act_d = 1'b1;
                    bc_d  = w_bc_inc;
                    // A beat carrying LST is a normal close even at the limit.
                    if (w_lst || (w_bc_inc == BC_MAX)) begin
                        abrt_d = !w_lst;
                        gnt_d  = '0;
                        if (GAP > 0) begin
                            state_d = ST_GAP;
                            gap_d   = GAP_LD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            bc_q    <= '0;
            gap_q   <= 4'd0;
            d_q     <= IDLE;
            act_q   <= 1'b0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            bc_q    <= bc_d;
            gap_q   <= gap_d;
            d_q     <= d_d;
            act_q   <= act_d;
            abrt_q  <= abrt_d;
        end
    end

    assign RDY  = w_rdy;
    assign GNT  = gnt_q;
    assign D    = d_q;
    assign ACT  = act_q;
    assign ABRT = abrt_q;

endmodule
`default_nettype wire

// File: tb/tb_ofd4_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofd4_arb
// Brief    : Directed and randomized self-checking bench for ofd4_arb.
// Revision : 1.0
// ============================================================================
module tb_ofd4_arb;

    localparam int         NREQ  = 4;
    localparam int         GAP   = 2;
    localparam int         MAXB  = 4;
    localparam logic [3:0] IDLEV = 4'h0;

    logic        CK = 1'b0;
    logic        RN = 1'b1;
    logic [3:0]  VLD = '0;
    logic [3:0]  LST = '0;
    logic [15:0] DAT = '0;
    logic [3:0]  RDY;
    logic [3:0]  D;
    logic        ACT;
    logic [3:0]  GNT;
    logic        ABRT;

    ofd4_arb #(
        .NREQ (NREQ),
        .GAP  (GAP),
        .MAXB (MAXB),
        .IDLE (IDLEV)
    ) dut (
        .CK   (CK),
        .RN   (RN),
        .VLD  (VLD),
        .LST  (LST),
        .DAT  (DAT),
        .RDY  (RDY),
        .D    (D),
        .ACT  (ACT),
        .GNT  (GNT),
        .ABRT (ABRT)
    );

    always #5 CK = ~CK;

    int ncmp  = 0;
    int nfail = 0;

    // Source queues: bit 4 = last flag, bits 3:0 = nibble.
    logic [4:0] srcq [NREQ][$];
    int         bub_pct   = 0;
    logic [3:0] force_off = '0;

    // Reference model: owner index, pointer, beats in grant, earliest arbitration edge.
    int         owner   = -1;
    int         ptr     = 0;
    int         beats   = 0;
    int         free_at = 0;
    int         edge_n  = 0;
    logic [3:0] exp_d;
    logic       exp_act;
    logic       exp_abrt;
    logic [3:0] exp_gnt;

    // Observed transfers.
    logic [3:0] log_d [$];
    int         log_e [$];
    logic [3:0] log_g [$];
    int         n_abrt = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < NREQ; i++) if (srcq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (srcq[i].size() > 0 && !force_off[i] && ($urandom_range(99) >= bub_pct)) begin
                VLD[i]        = 1'b1;
                DAT[4*i +: 4] = srcq[i][0][3:0];
                LST[i]        = srcq[i][0][4];
            end else begin
                VLD[i]        = 1'b0;
                DAT[4*i +: 4] = 4'($urandom);
                LST[i]        = 1'($urandom);
            end
        end
    endtask

    task automatic model_edge(input logic [3:0] v, input logic [3:0] l, input logic [15:0] d);
        logic [4:0] tmp;
        exp_d    = IDLEV;
        exp_act  = 1'b0;
        exp_abrt = 1'b0;
        if (owner < 0) begin
            if (edge_n >= free_at && v != 4'b0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = (ptr + k) % NREQ;
                    if (owner < 0 && v[c]) owner = c;
                end
                ptr   = (owner + 1) % NREQ;
                beats = 0;
            end
        end else if (v[owner]) begin
            exp_d   = d[4*owner +: 4];
            exp_act = 1'b1;
            beats++;
            tmp = srcq[owner].pop_front();
            if (l[owner] || beats == MAXB) begin
                exp_abrt = !l[owner];
                owner    = -1;
                free_at  = edge_n + GAP + 1;
            end
        end
        exp_gnt = (owner >= 0) ? 4'(1 << owner) : 4'b0;
        edge_n++;
    endtask

    task automatic model_reset();
        owner   = -1;
        ptr     = 0;
        beats   = 0;
        free_at = 0;
        edge_n  = 0;
        for (int i = 0; i < NREQ; i++) srcq[i].delete();
    endtask

    task automatic clear_logs();
        log_d.delete();
        log_e.delete();
        log_g.delete();
        n_abrt = 0;
    endtask

    task automatic tick();
        logic [3:0]  v;
        logic [3:0]  l;
        logic [3:0]  gp;
        logic [15:0] d;
        v  = VLD;
        l  = LST;
        d  = DAT;
        gp = GNT;
        @(posedge CK);
        model_edge(v, l, d);
        #1;
        chk("D",    16'(D),    16'(exp_d));
        chk("ACT",  16'(ACT),  16'(exp_act));
        chk("GNT",  16'(GNT),  16'(exp_gnt));
        chk("RDY",  16'(RDY),  16'(exp_gnt));
        chk("ABRT", 16'(ABRT), 16'(exp_abrt));
        if (ACT === 1'b1) begin
            log_d.push_back(D);
            log_e.push_back(edge_n);
            log_g.push_back(gp);
        end
        if (ABRT === 1'b1) n_abrt++;
    endtask

    task automatic step();
        drive();
        tick();
    endtask

    task automatic drain(input int budget);
        int cnt;
        cnt = 0;
        while ((pending() || owner >= 0) && cnt < budget) begin
            step();
            cnt++;
        end
        chk("drain_budget", 16'(cnt < budget), 16'd1);
        for (int i = 0; i < GAP + 1; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_D"},    16'(D),    16'(IDLEV));
        chk({tag, "_ACT"},  16'(ACT),  16'd0);
        chk({tag, "_GNT"},  16'(GNT),  16'd0);
        chk({tag, "_RDY"},  16'(RDY),  16'd0);
        chk({tag, "_ABRT"}, 16'(ABRT), 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #2 RN = 1'b0;
        #1 check_reset_outputs("rst_async");
        repeat (2) @(posedge CK);
        @(negedge CK) RN = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) step();

        // Single burst from requester 1.
        srcq[1].push_back(5'h0A);
        srcq[1].push_back(5'h0B);
        srcq[1].push_back(5'h1C);
        step(); chk("sb_gnt", 16'(GNT), 16'h2);
        step(); chk("sb_d0", 16'(D), 16'hA); chk("sb_act0", 16'(ACT), 16'd1);
        step(); chk("sb_d1", 16'(D), 16'hB);
        step(); chk("sb_d2", 16'(D), 16'hC); chk("sb_rel", 16'(GNT), 16'h0);
        step(); chk("sb_gap0", 16'(GNT), 16'h0);
        step(); chk("sb_gap1", 16'(ACT), 16'd0);
        step();

        // Round-robin between requesters 0 and 2 with 1-beat bursts.
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            srcq[0].push_back({1'b1, 4'(i)});
            srcq[2].push_back({1'b1, 4'(8 + i)});
        end
        drain(100);
        chk("rr_count", 16'(log_d.size()), 16'd8);
        for (int i = 1; i < log_d.size(); i++) begin
            chk("rr_alt", 16'(log_g[i] != log_g[i-1]), 16'd1);
            chk("rr_space", 16'(log_e[i] - log_e[i-1]), 16'(GAP + 2));
        end

        // Bubble: owner drops VLD for two cycles mid-burst.
        clear_logs();
        for (int i = 1; i <= 4; i++) srcq[1].push_back({(i == 4), 4'(i)});
        step(); chk("bub_gnt0", 16'(GNT), 16'h2);
        step();
        step();
        force_off = 4'b0010;
        step(); chk("bub_act0", 16'(ACT), 16'd0); chk("bub_hold0", 16'(GNT), 16'h2);
        step(); chk("bub_act1", 16'(ACT), 16'd0); chk("bub_hold1", 16'(GNT), 16'h2);
        force_off = 4'b0000;
        drain(50);
        chk("bub_count", 16'(log_d.size()), 16'd4);
        for (int i = 0; i < log_d.size(); i++) chk("bub_order", 16'(log_d[i]), 16'(i + 1));

        // Beat limit: 6 beats, LST on the sixth.
        clear_logs();
        for (int i = 1; i <= 6; i++) srcq[3].push_back({(i == 6), 4'(i)});
        drain(60);
        chk("bl_count", 16'(log_d.size()), 16'd6);
        chk("bl_abrt", 16'(n_abrt), 16'd1);
        for (int i = 0; i < log_d.size(); i++) chk("bl_order", 16'(log_d[i]), 16'(i + 1));
        if (log_e.size() == 6) chk("bl_regrant", 16'(log_e[4] - log_e[3]), 16'(GAP + 2));

        // LST exactly on the limit beat.
        clear_logs();
        for (int i = 1; i <= 4; i++) srcq[3].push_back({(i == 4), 4'(i + 4)});
        drain(40);
        chk("lim_count", 16'(log_d.size()), 16'd4);
        chk("lim_abrt", 16'(n_abrt), 16'd0);

        // Reset mid-burst after two beats, pointer restarts at 0.
        for (int i = 1; i <= 4; i++) srcq[1].push_back({(i == 4), 4'(i)});
        step();
        step();
        step(); chk("mid_beat2", 16'(D), 16'h2);
        #2 RN = 1'b0;
        #1 check_reset_outputs("rst_mid");
        model_reset();
        drive();
        @(negedge CK) RN = 1'b1;
        srcq[1].push_back(5'h15);
        srcq[3].push_back(5'h1E);
        step(); chk("rst_ptr", 16'(GNT), 16'h2);
        drain(40);

        // Randomized traffic with bubbles.
        bub_pct = 25;
        for (int c = 0; c < 800; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (srcq[r].size() < 4 && $urandom_range(7) == 0) begin
                    int len;
                    len = int'($urandom_range(1, 6));
                    for (int b = 0; b < len; b++) srcq[r].push_back({(b == len - 1), 4'($urandom)});
                end
            end
            step();
        end
        bub_pct = 0;
        drain(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
